// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl -- game-flow controller for a pong game.
//
// Sequences a game through NEWGAME -> PLAY -> NEWBALL/OVER, keeps a 2-digit
// BCD score and a ball reserve, and drives the countdown timer that paces
// the pause between balls and the game-over display.
//
// Ports:
//   clk          in   system clock, all state changes on rising edge
//   reset        in   synchronous, active-high reset
//   btn[1:0]     in   player buttons, any non-zero value counts as pressed
//   refresh_tick in   one-clk pulse per video frame
//   hit          in   one-clk pulse, ball struck by paddle
//   miss         in   one-clk pulse, ball passed paddle
//   timer_up     in   countdown timer expired (level)
//   timer_start  out  one-clk registered pulse reloading the countdown timer
//   timer_tick   out  countdown decrement strobe (refresh_tick passed through)
//   graph_still  out  1 = freeze ball/paddle motion (all states except PLAY)
//   game_over    out  1 while in OVER
//   dig0[3:0]    out  BCD score units
//   dig1[3:0]    out  BCD score tens
//   balls[1:0]   out  balls remaining in reserve
module pong_game_ctrl #(
  parameter int INIT_BALLS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refresh_tick,
  input  logic       hit,
  input  logic       miss,
  input  logic       timer_up,
  output logic       timer_start,
  output logic       timer_tick,
  output logic       graph_still,
  output logic       game_over,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] balls
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] INIT_BALLS_L = 2'(INIT_BALLS);

  state_t     state_q, state_d;
  logic [1:0] balls_q, balls_d;
  logic [3:0] dig0_q, dig0_d;
  logic [3:0] dig1_q, dig1_d;
  logic       timer_start_q, timer_start_d;
  logic       pressed;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                         input logic [3:0] units);
    logic [3:0] t;
    logic [3:0] u;
    t = tens;
    u = units;
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  // Saturating decrement so the reserve never wraps below zero.
  function automatic logic [1:0] ball_dec(input logic [1:0] b);
    return (b == 2'd0) ? 2'd0 : b - 2'd1;
  endfunction

  assign pressed = (btn != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= NEWGAME;
      balls_q       <= INIT_BALLS_L;
      dig0_q        <= 4'd0;
      dig1_q        <= 4'd0;
      timer_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      balls_q       <= balls_d;
      dig0_q        <= dig0_d;
      dig1_q        <= dig1_d;
      timer_start_q <= timer_start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    balls_d       = balls_q;
    dig0_d        = dig0_q;
    dig1_d        = dig1_q;
    timer_start_d = 1'b0;
    unique case (state_q)
      NEWGAME: begin
        if (pressed) begin
          state_d = PLAY;
          dig0_d  = 4'd0;
          dig1_d  = 4'd0;
          balls_d = ball_dec(balls_q);
        end
      end
      PLAY: begin
        // hit and miss are independent; both apply when coincident.
        if (hit) {dig1_d, dig0_d} = bcd_inc(dig1_q, dig0_q);
        if (miss) begin
          timer_start_d = 1'b1;
          if (balls_q == 2'd0) begin
            state_d = OVER;
          end else begin
            state_d = NEWBALL;
            balls_d = ball_dec(balls_q);
          end
        end
      end
      NEWBALL: begin
        if (timer_up && pressed) state_d = PLAY;
      end
      OVER: begin
        // timer_up is stale while the reload pulse is still out.
        if (timer_up && !timer_start_q) begin
          state_d = NEWGAME;
          balls_d = INIT_BALLS_L;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // Output logic
  always_comb begin
    graph_still = (state_q != PLAY);
    game_over   = (state_q == OVER);
  end

  assign timer_tick  = refresh_tick;
  assign timer_start = timer_start_q;
  assign dig0        = dig0_q;
  assign dig1        = dig1_q;
  assign balls       = balls_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] btn;
  logic       refresh_tick;
  logic       hit;
  logic       miss;
  logic       timer_up;
  logic       timer_start;
  logic       timer_tick;
  logic       graph_still;
  logic       game_over;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [1:0] balls;

  int n_checks;
  int n_fail;

  pong_game_ctrl #(.INIT_BALLS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .refresh_tick (refresh_tick),
    .hit          (hit),
    .miss         (miss),
    .timer_up     (timer_up),
    .timer_start  (timer_start),
    .timer_tick   (timer_tick),
    .graph_still  (graph_still),
    .game_over    (game_over),
    .dig0         (dig0),
    .dig1         (dig1),
    .balls        (balls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (graph_still !== 1'b1 || game_over !== 1'b0 || timer_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: still=%b over=%b tstart=%b, want 1 0 0", graph_still, game_over, timer_start);
    end
    n_checks++;
    if (balls !== 2'd3 || dig1 !== 4'd0 || dig0 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data: balls=%0d score=%0d%0d, want 3 00", balls, dig1, dig0);
    end
  endtask

  task automatic test_timer_tick();
    refresh_tick = 1'b1;
    #1;
    n_checks++;
    if (timer_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL timer_tick_hi: got %b want 1", timer_tick);
    end
    refresh_tick = 1'b0;
    #1;
    n_checks++;
    if (timer_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_tick_lo: got %b want 0", timer_tick);
    end
  endtask

  task automatic test_start();
    // hit/miss ignored in NEWGAME
    hit = 1'b1;
    miss = 1'b1;
    tick();
    hit = 1'b0;
    miss = 1'b0;
    n_checks++;
    if (dig0 !== 4'd0 || graph_still !== 1'b1 || balls !== 2'd3 || timer_start !== 1'b0) begin
      n_fail++;
      $display("FAIL newgame_ignore: dig0=%0d still=%b balls=%0d tstart=%b, want 0 1 3 0", dig0, graph_still, balls, timer_start);
    end
    btn = 2'b01;
    tick();
    btn = 2'b00;
    n_checks++;
    if (graph_still !== 1'b0 || balls !== 2'd2 || dig1 !== 4'd0 || dig0 !== 4'd0) begin
      n_fail++;
      $display("FAIL start_play: still=%b balls=%0d score=%0d%0d, want 0 2 00", graph_still, balls, dig1, dig0);
    end
  endtask

  task automatic test_score();
    hit = 1'b1;
    repeat (12) tick();
    hit = 1'b0;
    tick();
    n_checks++;
    if (dig1 !== 4'd1 || dig0 !== 4'd2) begin
      n_fail++;
      $display("FAIL score_12: got %0d%0d want 12", dig1, dig0);
    end
    hit = 1'b1;
    repeat (87) tick();
    hit = 1'b0;
    n_checks++;
    if (dig1 !== 4'd9 || dig0 !== 4'd9) begin
      n_fail++;
      $display("FAIL score_99: got %0d%0d want 99", dig1, dig0);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    n_checks++;
    if (dig1 !== 4'd0 || dig0 !== 4'd0) begin
      n_fail++;
      $display("FAIL score_wrap: got %0d%0d want 00", dig1, dig0);
    end
  endtask

  task automatic test_miss();
    miss = 1'b1;
    tick();
    miss = 1'b0;
    n_checks++;
    if (timer_start !== 1'b1 || graph_still !== 1'b1 || balls !== 2'd1 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_newball: tstart=%b still=%b balls=%0d over=%b, want 1 1 1 0", timer_start, graph_still, balls, game_over);
    end
    btn = 2'b10;
    hit = 1'b1;
    tick();
    n_checks++;
    if (timer_start !== 1'b0) begin
      n_fail++;
      $display("FAIL tstart_pulse: got %b want 0", timer_start);
    end
    tick();
    tick();
    hit = 1'b0;
    n_checks++;
    if (graph_still !== 1'b1 || dig0 !== 4'd0 || balls !== 2'd1) begin
      n_fail++;
      $display("FAIL newball_hold: still=%b dig0=%0d balls=%0d, want 1 0 1", graph_still, dig0, balls);
    end
    timer_up = 1'b1;
    tick();
    timer_up = 1'b0;
    btn = 2'b00;
    n_checks++;
    if (graph_still !== 1'b0) begin
      n_fail++;
      $display("FAIL newball_resume: still=%b want 0", graph_still);
    end
  endtask

  task automatic test_hit_miss();
    hit = 1'b1;
    miss = 1'b1;
    tick();
    hit = 1'b0;
    miss = 1'b0;
    n_checks++;
    if (dig0 !== 4'd1 || graph_still !== 1'b1 || balls !== 2'd0 || timer_start !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_and_miss: dig0=%0d still=%b balls=%0d tstart=%b, want 1 1 0 1", dig0, graph_still, balls, timer_start);
    end
    tick();
    btn = 2'b01;
    timer_up = 1'b1;
    tick();
    btn = 2'b00;
    timer_up = 1'b0;
    n_checks++;
    if (graph_still !== 1'b0) begin
      n_fail++;
      $display("FAIL resume2: still=%b want 0", graph_still);
    end
  endtask

  task automatic test_over();
    miss = 1'b1;
    tick();
    miss = 1'b0;
    n_checks++;
    if (game_over !== 1'b1 || balls !== 2'd0 || timer_start !== 1'b1 || graph_still !== 1'b1) begin
      n_fail++;
      $display("FAIL enter_over: over=%b balls=%0d tstart=%b still=%b, want 1 0 1 1", game_over, balls, timer_start, graph_still);
    end
    // timer_up during the reload-pulse cycle must be ignored
    timer_up = 1'b1;
    tick();
    n_checks++;
    if (game_over !== 1'b1 || timer_start !== 1'b0 || balls !== 2'd0) begin
      n_fail++;
      $display("FAIL over_stale_timer: over=%b tstart=%b balls=%0d, want 1 0 0", game_over, timer_start, balls);
    end
    tick();
    timer_up = 1'b0;
    n_checks++;
    if (game_over !== 1'b0 || graph_still !== 1'b1 || balls !== 2'd3 || dig1 !== 4'd0 || dig0 !== 4'd1) begin
      n_fail++;
      $display("FAIL over_to_newgame: over=%b still=%b balls=%0d score=%0d%0d, want 0 1 3 01", game_over, graph_still, balls, dig1, dig0);
    end
    btn = 2'b11;
    tick();
    btn = 2'b00;
    n_checks++;
    if (graph_still !== 1'b0 || balls !== 2'd2 || dig0 !== 4'd0) begin
      n_fail++;
      $display("FAIL restart: still=%b balls=%0d dig0=%0d, want 0 2 0", graph_still, balls, dig0);
    end
  endtask

  task automatic test_reset_mid();
    hit = 1'b1;
    repeat (37) tick();
    hit = 1'b0;
    miss = 1'b1;
    tick();
    miss = 1'b0;
    n_checks++;
    if (dig1 !== 4'd3 || dig0 !== 4'd7 || balls !== 2'd1 || graph_still !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: score=%0d%0d balls=%0d still=%b, want 37 1 1", dig1, dig0, balls, graph_still);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (dig1 !== 4'd0 || dig0 !== 4'd0 || balls !== 2'd3 || timer_start !== 1'b0 || graph_still !== 1'b1 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: score=%0d%0d balls=%0d tstart=%b still=%b over=%b, want 00 3 0 1 0", dig1, dig0, balls, timer_start, graph_still, game_over);
    end
    // NEWGAME (not NEWBALL) leaves on a button alone
    btn = 2'b01;
    tick();
    btn = 2'b00;
    n_checks++;
    if (graph_still !== 1'b0 || balls !== 2'd2) begin
      n_fail++;
      $display("FAIL post_reset_start: still=%b balls=%0d, want 0 2", graph_still, balls);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    btn = 2'b00;
    refresh_tick = 1'b0;
    hit = 1'b0;
    miss = 1'b0;
    timer_up = 1'b0;
    #2;
    test_reset();
    test_timer_tick();
    test_start();
    test_score();
    test_miss();
    test_hit_miss();
    test_over();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter INIT_BALLS, default 3: balls in reserve at game start; legal range 1..3.
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port btn, input, 2: player buttons; "pressed" means btn != 0.
REQ-005 SHALL have port refresh_tick, input, 1: one-clk pulse per video frame.
REQ-006 SHALL have port hit, input, 1: one-clk pulse, ball struck by paddle.
REQ-007 SHALL have port miss, input, 1: one-clk pulse, ball passed paddle.
REQ-008 SHALL have port timer_up, input, 1: countdown timer expired (level).
REQ-009 SHALL have port timer_start, output, 1: one-clk pulse that reloads the countdown timer.
REQ-010 SHALL have port timer_tick, output, 1: decrement strobe for the countdown timer.
REQ-011 SHALL have port graph_still, output, 1: 1 = freeze ball/paddle motion.
REQ-012 SHALL have port game_over, output, 1: 1 while in OVER.
REQ-013 SHALL have port dig0, output, 4: BCD score units.
REQ-014 SHALL have port dig1, output, 4: BCD score tens.
REQ-015 SHALL have port balls, output, 2: balls remaining in reserve.

Function
REQ-016 SHALL implement a four-state FSM: NEWGAME, PLAY, NEWBALL, OVER.
REQ-017 SHALL drive timer_tick = refresh_tick combinationally, zero latency, in all states.
REQ-018 SHALL assert graph_still = 1 in NEWGAME, NEWBALL and OVER, and 0 in PLAY (Moore).
REQ-019 SHALL assert game_over = 1 only in OVER (Moore).
REQ-020 NEWGAME, button pressed: go to PLAY, clear dig1/dig0 to 00, and decrement balls by 1; otherwise hold.
REQ-021 PLAY, hit: increment score as 2-digit BCD (units 9 -> 0 with tens +1); 99 + 1 wraps to 00.
REQ-022 PLAY, miss with balls != 0: go to NEWBALL and decrement balls by 1.
REQ-023 PLAY, miss with balls == 0: go to OVER; balls stays 0.
REQ-024 PLAY, miss: timer_start SHALL be a registered pulse, high exactly one clk, in the first cycle of NEWBALL/OVER.
REQ-025 PLAY, hit and miss in the same cycle: apply both the score increment and the miss handling.
REQ-026 hit and miss SHALL be ignored outside PLAY.
REQ-027 NEWBALL: go to PLAY only when timer_up = 1 and a button is pressed in the same cycle; otherwise hold.
REQ-028 OVER, timer_up = 1: go to NEWGAME and reload balls = INIT_BALLS; score is retained for display.
REQ-029 timer_up SHALL be ignored in OVER during the cycle timer_start is high (the timer has not yet reloaded).
REQ-030 The balls decrement SHALL never underflow below 0.

Reset
REQ-031 While reset = 1 at a clk edge: state = NEWGAME, balls = INIT_BALLS, dig1/dig0 = 0/0, timer_start = 0; this overrides all other inputs.
REQ-032 The first cycle after reset release SHALL show graph_still = 1, game_over = 0, timer_start = 0.
REQ-033 Reset asserted mid-game (any state) SHALL abort the game to the REQ-031 values on the next edge.

Verification
REQ-034 Reset, then btn = 01 for 1 clk -> next cycle state PLAY, graph_still = 0, balls = 2, score 00.
REQ-035 In PLAY, 12 hit pulses -> dig1 = 1, dig0 = 2; from 99, one hit -> 00.
REQ-036 In PLAY, miss with balls = 2 -> next cycle timer_start = 1 for exactly 1 clk, graph_still = 1, balls = 1; btn held with timer_up = 0 -> stays NEWBALL; timer_up = 1 with btn -> PLAY.
REQ-037 Three misses from game start -> OVER, game_over = 1, balls = 0; then timer_up = 1 -> NEWGAME, balls = 3, score retained until the next button press clears it.
REQ-038 Simultaneous hit and miss in PLAY -> score +1 and the NEWBALL transition both occur; refresh_tick pulses -> timer_tick mirrors them in the same cycle.
REQ-039 Reset pulse while in NEWBALL with score 37 -> next cycle NEWGAME, score 00, balls = 3, timer_start = 0.
